axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 The block SHALL have parameter C_TIMEOUT_CYCLES, default 1024, giving the cycles allowed from issue to completion; 0 disables the timeout.
REQ-002 The block SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, which is fixed at 32 and gives the AXI data width.
REQ-003 M_AXI_ACLK  in  1  sole clock; all logic is rising-edge.
REQ-004 M_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-005 cmd_vld  in  1  command valid.
REQ-006 cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
REQ-007 cmd_wr  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  32  byte address, passed to the bus unaltered.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 cmd_wstrb  in  4  write byte strobes.
REQ-011 rsp_vld  out  1  response valid; held until rsp_rdy.
REQ-012 rsp_rdy  in  1  response accepted when rsp_vld & rsp_rdy.
REQ-013 rsp_rdata  out  32  read data (0 for writes and timeouts).
REQ-014 rsp_resp  out  2  RRESP/BRESP captured, or 2'b10 on timeout.
REQ-015 rsp_timeout  out  1  transaction aborted by the timeout.
REQ-016 M_AXI_AWADDR/AWPROT/AWVALID  out  32/3/1; M_AXI_AWREADY  in  1  write address channel.
REQ-017 M_AXI_WDATA/WSTRB/WVALID  out  32/4/1; M_AXI_WREADY  in  1  write data channel.
REQ-018 M_AXI_BRESP/BVALID  in  2/1; M_AXI_BREADY  out  1  write response channel.
REQ-019 M_AXI_ARADDR/ARPROT/ARVALID  out  32/3/1; M_AXI_ARREADY  in  1  read address channel.
REQ-020 M_AXI_RDATA/RRESP/RVALID  in  32/2/1; M_AXI_RREADY  out  1  read data channel.

Function
REQ-021 The state machine SHALL have states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA and RESP.
REQ-022 cmd_rdy SHALL be 1 only in IDLE; on acceptance the block SHALL register addr, wdata and wstrb, then enter WR_ADDR when cmd_wr=1, else RD_ADDR.
REQ-023 In WR_ADDR, AWVALID and WVALID SHALL both assert in the first cycle of the state.
REQ-024 In WR_ADDR, each of AWVALID and WVALID SHALL drop independently on its own handshake, and the state SHALL exit to WR_RESP once both handshakes are done, including when they complete in the same cycle.
REQ-025 AWADDR, WDATA and WSTRB SHALL stay stable while their VALID is high.
REQ-026 BREADY SHALL be 1 only in WR_RESP; on BVALID the block SHALL capture BRESP and enter RESP.
REQ-027 In RD_ADDR, ARVALID SHALL be held until ARREADY, then the state SHALL move to RD_DATA.
REQ-028 RREADY SHALL be 1 only in RD_DATA; on RVALID the block SHALL capture RDATA and RRESP and enter RESP.
REQ-029 AWPROT and ARPROT SHALL be constant 3'b000.
REQ-030 In RESP, rsp_vld SHALL be 1; on rsp_rdy the state SHALL return to IDLE, giving at most one transaction outstanding.
REQ-031 Minimum latency SHALL be 3 cycles from cmd acceptance to rsp_vld when the slave responds at once: issue, handshake, capture.
REQ-032 A 16-bit timeout counter SHALL clear on cmd acceptance and increment in every non-IDLE, non-RESP state.
REQ-033 When the timeout counter reaches C_TIMEOUT_CYCLES, the block SHALL deassert all VALID/READY outputs, set rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0, and enter RESP.
REQ-034 A channel handshake in the same cycle the timeout is reached SHALL take priority, and the transaction SHALL complete normally.
REQ-035 A late BVALID or RVALID after a timeout SHALL be ignored, because READY is low.
REQ-036 rsp_resp SHALL pass SLVERR and DECERR from the slave through unmodified, with rsp_timeout=0.

Reset
REQ-037 Asserting M_AXI_ARESETN low SHALL immediately force IDLE and clear all VALID/READY outputs, rsp_vld, rsp_resp, rsp_rdata, rsp_timeout and the timeout counter.
REQ-038 After reset is released, cmd_rdy SHALL be 1 on the first clock edge.
REQ-039 Reset asserted mid-transaction SHALL abandon that transaction, and no response SHALL be issued for it.

Verification
REQ-040 Write addr=0x10, data=0xDEADBEEF, wstrb=0xF to a zero-wait slave -> AW/W handshakes in the same cycle, BREADY for one cycle, rsp_vld with rsp_resp=0 and rsp_timeout=0.
REQ-041 Read addr=0x24 with slave RDATA=0x12345678 after a 5-cycle ARREADY delay -> ARADDR=0x24 held stable for 6 cycles, rsp_rdata=0x12345678.
REQ-042 Write where WREADY comes 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID stays high, and exactly one B handshake follows.
REQ-043 Read with C_TIMEOUT_CYCLES=8 to a slave that never asserts ARREADY -> ARVALID drops after 8 cycles, rsp_resp=2'b10, rsp_timeout=1.
REQ-044 rsp_rdy held low for 10 cycles, then pulsed -> rsp_vld and response fields stable for those 10 cycles, cmd_rdy=0 throughout, cmd_rdy=1 the next cycle.
REQ-045 Reset asserted while in WR_RESP -> all outputs cleared asynchronously and no rsp_vld after release.

Source files
------------

// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// axi_lite_master
//
// Turns a simple command/response handshake into single AXI4-Lite read or
// write transactions. Only one transaction is ever outstanding. Every
// non-IDLE, non-RESP state is guarded by a timeout counter. When the counter
// expires, the transaction is abandoned and a SLVERR-coded response is
// returned with rsp_timeout set.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN      : clock (rising edge), async active-low reset
//   cmd_vld/cmd_rdy                : command handshake
//   cmd_wr, cmd_addr,
//   cmd_wdata, cmd_wstrb           : command payload (1 = write, 0 = read)
//   rsp_vld/rsp_rdy                : response handshake (rsp_vld held until taken)
//   rsp_rdata, rsp_resp,
//   rsp_timeout                    : response payload
//   M_AXI_AW*, M_AXI_W*, M_AXI_B*  : AXI4-Lite write channels
//   M_AXI_AR*, M_AXI_R*            : AXI4-Lite read channels
// ---------------------------------------------------------------------------
module axi_lite_master #(
    parameter int C_TIMEOUT_CYCLES   = 1024,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,

    input  logic                            cmd_vld,
    output logic                            cmd_rdy,
    input  logic                            cmd_wr,
    input  logic [31:0]                     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [3:0]                      cmd_wstrb,

    output logic                            rsp_vld,
    input  logic                            rsp_rdy,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,

    output logic [31:0]                     M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                      M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [31:0]                     M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_t;

    // The counter is 16 bits wide, so only the low 16 bits of the limit matter.
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(C_TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_EN    = (C_TIMEOUT_CYCLES != 0);

    state_t                          state;
    logic [15:0]                     timer;
    logic [31:0]                     addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]                      wstrb_q;

    logic [15:0] timer_inc;
    logic        timeout_hit;
    logic        aw_left;
    logic        w_left;

    // The timeout fires on the edge where the incremented count would reach
    // the limit. A transaction therefore gets exactly C_TIMEOUT_CYCLES cycles
    // of bus activity.
    assign timer_inc   = timer + 16'd1;
    assign timeout_hit = TIMEOUT_EN && (timer_inc == TIMEOUT_LIMIT);

    // AW and W channels still waiting after this cycle.
    assign aw_left = M_AXI_AWVALID && !M_AXI_AWREADY;
    assign w_left  = M_AXI_WVALID  && !M_AXI_WREADY;

    // Payload comes straight from registers captured at acceptance.
    // It is therefore stable for as long as any VALID is high.
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    // Single-process FSM. All handshake and response outputs are registered.
    // In each bus state, a completing handshake is checked before the timeout,
    // so a handshake that lands on the expiry cycle still wins.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= IDLE;
            cmd_rdy       <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_vld       <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
            timer         <= 16'd0;
            addr_q        <= 32'd0;
            wdata_q       <= '0;
            wstrb_q       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_rdy <= 1'b1;
                    if (cmd_vld && cmd_rdy) begin
                        cmd_rdy <= 1'b0;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        timer   <= 16'd0;
                        if (cmd_wr) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR_ADDR;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end

                WR_ADDR: begin
                    timer <= timer_inc;
                    if (!aw_left && !w_left) begin
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b0;
                        M_AXI_BREADY  <= 1'b1;
                        state         <= WR_RESP;
                    end else if (timeout_hit) begin
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b0;
                        rsp_vld       <= 1'b1;
                        rsp_resp      <= 2'b10;
                        rsp_rdata     <= '0;
                        rsp_timeout   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        M_AXI_AWVALID <= aw_left;
                        M_AXI_WVALID  <= w_left;
                    end
                end

                WR_RESP: begin
                    timer <= timer_inc;
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_vld      <= 1'b1;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        rsp_timeout  <= 1'b0;
                        state        <= RESP;
                    end else if (timeout_hit) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_vld      <= 1'b1;
                        rsp_resp     <= 2'b10;
                        rsp_rdata    <= '0;
                        rsp_timeout  <= 1'b1;
                        state        <= RESP;
                    end
                end

                RD_ADDR: begin
                    timer <= timer_inc;
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_DATA;
                    end else if (timeout_hit) begin
                        M_AXI_ARVALID <= 1'b0;
                        rsp_vld       <= 1'b1;
                        rsp_resp      <= 2'b10;
                        rsp_rdata     <= '0;
                        rsp_timeout   <= 1'b1;
                        state         <= RESP;
                    end
                end

                RD_DATA: begin
                    timer <= timer_inc;
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_vld      <= 1'b1;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_timeout  <= 1'b0;
                        state        <= RESP;
                    end else if (timeout_hit) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_vld      <= 1'b1;
                        rsp_resp     <= 2'b10;
                        rsp_rdata    <= '0;
                        rsp_timeout  <= 1'b1;
                        state        <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        cmd_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master
//
// Directed bench for axi_lite_master. The bench acts as the AXI slave and
// as the command/response user. Inputs are driven and outputs are sampled
// 1 ns after each rising edge. The timeout is built at 8 cycles, so the
// timeout scenario stays short.
// ---------------------------------------------------------------------------
module tb_axi_lite_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks_passed;
    int checks_total;
    int b_count;

    axi_lite_master #(
        .C_TIMEOUT_CYCLES   (8),
        .C_M_AXI_DATA_WIDTH (32)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .cmd_vld       (cmd_vld),
        .cmd_rdy       (cmd_rdy),
        .cmd_wr        (cmd_wr),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_vld       (rsp_vld),
        .rsp_rdy       (rsp_rdy),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every B-channel handshake the DUT takes part in.
    always @(posedge clk) begin
        if (bvalid && bready) b_count <= b_count + 1;
    end

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for cmd_rdy, then present one command for a single edge.
    // Returns in the first cycle of the issued transaction.
    task automatic issue_cmd(input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        while (!cmd_rdy && n < 20) begin
            step();
            n++;
        end
        if (!cmd_rdy) begin
            checks_total++;
            $display("[TB] FAIL cmd_rdy_wait: got %b expected 1", cmd_rdy);
        end
        cmd_vld   = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        step();
        cmd_vld   = 1'b0;
    endtask

    task automatic pulse_rsp_rdy();
        rsp_rdy = 1'b1;
        step();
        rsp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        #22;
        checks_total++;
        if ({cmd_rdy, awvalid, wvalid, bready, arvalid, rready, rsp_vld, rsp_timeout} !== 8'b0)
            $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
                     {cmd_rdy, awvalid, wvalid, bready, arvalid, rready, rsp_vld, rsp_timeout});
        else checks_passed++;
        checks_total++;
        if ({rsp_resp, rsp_rdata} !== 34'd0)
            $display("[TB] FAIL reset_rsp: got resp=%b rdata=%h expected 0", rsp_resp, rsp_rdata);
        else checks_passed++;
        rst_n = 1'b1;
        step();
        checks_total++;
        if (cmd_rdy !== 1'b1)
            $display("[TB] FAIL reset_cmd_rdy: got %b expected 1", cmd_rdy);
        else checks_passed++;
    endtask

    task automatic test_write_zero_wait();
        int b_before;
        awready = 1'b1;
        wready  = 1'b1;
        b_before = b_count;
        issue_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        checks_total++;
        if ({awvalid, wvalid, cmd_rdy} !== 3'b110)
            $display("[TB] FAIL wr0_issue: got aw/w/cmd_rdy=%b expected 110", {awvalid, wvalid, cmd_rdy});
        else checks_passed++;
        checks_total++;
        if ({awaddr, wdata, wstrb, awprot} !== {32'h10, 32'hDEADBEEF, 4'hF, 3'b000})
            $display("[TB] FAIL wr0_payload: got %h %h %h %b expected 00000010 deadbeef f 000",
                     awaddr, wdata, wstrb, awprot);
        else checks_passed++;
        step();
        checks_total++;
        if ({awvalid, wvalid, bready} !== 3'b001)
            $display("[TB] FAIL wr0_bready: got aw/w/b=%b expected 001", {awvalid, wvalid, bready});
        else checks_passed++;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b1;
        bresp   = 2'b00;
        step();
        bvalid  = 1'b0;
        checks_total++;
        if ({bready, rsp_vld, rsp_timeout, rsp_resp} !== 5'b01000 || rsp_rdata !== 32'd0)
            $display("[TB] FAIL wr0_rsp: got b/vld/to/resp=%b rdata=%h expected 01000 0",
                     {bready, rsp_vld, rsp_timeout, rsp_resp}, rsp_rdata);
        else checks_passed++;
        checks_total++;
        if (b_count - b_before !== 1)
            $display("[TB] FAIL wr0_bcount: got %0d expected 1", b_count - b_before);
        else checks_passed++;
        pulse_rsp_rdy();
        checks_total++;
        if ({rsp_vld, cmd_rdy} !== 2'b01)
            $display("[TB] FAIL wr0_done: got vld/cmd_rdy=%b expected 01", {rsp_vld, cmd_rdy});
        else checks_passed++;
    endtask

    task automatic test_read_delay();
        int bad;
        arready = 1'b0;
        issue_cmd(1'b0, 32'h24, 32'h0, 4'h0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) arready = 1'b1;
            if (arvalid !== 1'b1 || araddr !== 32'h24 || arprot !== 3'b000) bad++;
            if (i < 5) step();
        end
        checks_total++;
        if (bad != 0)
            $display("[TB] FAIL rd_ar_hold: got %0d bad cycles expected 0", bad);
        else checks_passed++;
        step();
        arready = 1'b0;
        checks_total++;
        if ({arvalid, rready} !== 2'b01)
            $display("[TB] FAIL rd_rready: got ar/r=%b expected 01", {arvalid, rready});
        else checks_passed++;
        rvalid = 1'b1;
        rdata  = 32'h12345678;
        rresp  = 2'b00;
        step();
        rvalid = 1'b0;
        checks_total++;
        if ({rready, rsp_vld, rsp_timeout, rsp_resp} !== 5'b01000 || rsp_rdata !== 32'h12345678)
            $display("[TB] FAIL rd_rsp: got r/vld/to/resp=%b rdata=%h expected 01000 12345678",
                     {rready, rsp_vld, rsp_timeout, rsp_resp}, rsp_rdata);
        else checks_passed++;
        pulse_rsp_rdy();
    endtask

    task automatic test_write_staggered();
        int b_before;
        b_before = b_count;
        awready = 1'b1;
        wready  = 1'b0;
        issue_cmd(1'b1, 32'h40, 32'hCAFEF00D, 4'h3);
        step();
        awready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) wready = 1'b1;
            checks_total++;
            if ({awvalid, wvalid, bready} !== 3'b010 || wdata !== 32'hCAFEF00D || wstrb !== 4'h3)
                $display("[TB] FAIL wr_stag_w%0d: got aw/w/b=%b wdata=%h expected 010 cafef00d",
                         i, {awvalid, wvalid, bready}, wdata);
            else checks_passed++;
            step();
        end
        wready = 1'b0;
        checks_total++;
        if ({awvalid, wvalid, bready} !== 3'b001)
            $display("[TB] FAIL wr_stag_bready: got aw/w/b=%b expected 001", {awvalid, wvalid, bready});
        else checks_passed++;
        // BVALID lingers a second cycle; only the first may be taken.
        bvalid = 1'b1;
        bresp  = 2'b10;
        step();
        step();
        bvalid = 1'b0;
        bresp  = 2'b00;
        checks_total++;
        if ({rsp_vld, rsp_timeout, rsp_resp} !== 4'b1010)
            $display("[TB] FAIL wr_stag_slverr: got vld/to/resp=%b expected 1010",
                     {rsp_vld, rsp_timeout, rsp_resp});
        else checks_passed++;
        checks_total++;
        if (b_count - b_before !== 1)
            $display("[TB] FAIL wr_stag_bcount: got %0d expected 1", b_count - b_before);
        else checks_passed++;
        pulse_rsp_rdy();
    endtask

    task automatic test_read_timeout();
        int bad;
        arready = 1'b0;
        issue_cmd(1'b0, 32'h80, 32'h0, 4'h0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (arvalid !== 1'b1 || rsp_vld !== 1'b0) bad++;
            step();
        end
        checks_total++;
        if (bad != 0)
            $display("[TB] FAIL to_ar_hold: got %0d bad cycles expected 0", bad);
        else checks_passed++;
        checks_total++;
        if ({arvalid, rready, rsp_vld, rsp_timeout, rsp_resp} !== 6'b001110 || rsp_rdata !== 32'd0)
            $display("[TB] FAIL to_rsp: got ar/r/vld/to/resp=%b rdata=%h expected 001110 0",
                     {arvalid, rready, rsp_vld, rsp_timeout, rsp_resp}, rsp_rdata);
        else checks_passed++;
        rvalid = 1'b1;
        rdata  = 32'hFFFFFFFF;
        step();
        checks_total++;
        if (rsp_rdata !== 32'd0 || rready !== 1'b0 || rsp_timeout !== 1'b1)
            $display("[TB] FAIL to_late_r: got rdata=%h rready=%b to=%b expected 0 0 1",
                     rsp_rdata, rready, rsp_timeout);
        else checks_passed++;
        rvalid = 1'b0;
        pulse_rsp_rdy();
    endtask

    task automatic test_rsp_hold();
        int bad;
        arready = 1'b1;
        issue_cmd(1'b0, 32'h100, 32'h0, 4'h0);
        step();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hA5A50F0F;
        rresp   = 2'b11;
        step();
        rvalid  = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_vld !== 1'b1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'hA5A50F0F ||
                rsp_timeout !== 1'b0 || cmd_rdy !== 1'b0) bad++;
            step();
        end
        checks_total++;
        if (bad != 0)
            $display("[TB] FAIL hold_stable: got %0d bad cycles expected 0", bad);
        else checks_passed++;
        pulse_rsp_rdy();
        checks_total++;
        if ({rsp_vld, cmd_rdy} !== 2'b01)
            $display("[TB] FAIL hold_release: got vld/cmd_rdy=%b expected 01", {rsp_vld, cmd_rdy});
        else checks_passed++;
    endtask

    task automatic test_reset_mid();
        int bad;
        awready = 1'b1;
        wready  = 1'b1;
        issue_cmd(1'b1, 32'h200, 32'h11223344, 4'h1);
        step();
        awready = 1'b0;
        wready  = 1'b0;
        checks_total++;
        if (bready !== 1'b1)
            $display("[TB] FAIL rst_mid_in_wresp: got bready=%b expected 1", bready);
        else checks_passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks_total++;
        if ({cmd_rdy, awvalid, wvalid, bready, arvalid, rready, rsp_vld} !== 7'b0)
            $display("[TB] FAIL rst_mid_async: got %b expected 0000000",
                     {cmd_rdy, awvalid, wvalid, bready, arvalid, rready, rsp_vld});
        else checks_passed++;
        step();
        #3;
        rst_n  = 1'b1;
        bvalid = 1'b1;
        bresp  = 2'b00;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_vld !== 1'b0 || bready !== 1'b0 || cmd_rdy !== 1'b1) bad++;
        end
        bvalid = 1'b0;
        checks_total++;
        if (bad != 0)
            $display("[TB] FAIL rst_mid_no_rsp: got %0d bad cycles expected 0", bad);
        else checks_passed++;
    endtask

    initial begin
        checks_passed = 0;
        checks_total  = 0;
        b_count   = 0;
        rst_n     = 1'b0;
        cmd_vld   = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'd0;
        cmd_wdata = 32'd0;
        cmd_wstrb = 4'd0;
        rsp_rdy   = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bresp     = 2'b00;
        bvalid    = 1'b0;
        arready   = 1'b0;
        rdata     = 32'd0;
        rresp     = 2'b00;
        rvalid    = 1'b0;

        test_reset();
        test_write_zero_wait();
        test_read_delay();
        test_write_staggered();
        test_read_timeout();
        test_rsp_hold();
        test_reset_mid();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
